// File: rtl/mux2t1_sync.sv
// Registered 2-to-1 selector with valid qualification and a saturating select-transition counter.
// Optional even-parity output o_par is enabled by defining MUX2T1_PARITY_EN.
module mux2t1_sync #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  output logic             sel_q,
  output logic [CNT_W-1:0] sel_changes
`ifdef MUX2T1_PARITY_EN
  ,
  output logic             o_par
`endif
);

  logic [WIDTH-1:0] w_sel_data;
  logic             w_toggle;
  logic             w_cnt_sat;

  logic [WIDTH-1:0] r_o;
  logic             r_vld;
  logic             r_sel_q;
  logic [CNT_W-1:0] r_cnt;

  assign w_sel_data = sel ? b : a;
  assign w_toggle   = in_valid && (sel != r_sel_q);
  assign w_cnt_sat  = &r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_o     <= '0;
      r_vld   <= 1'b0;
      r_sel_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_o     <= w_sel_data;
        r_sel_q <= sel;
      end
      // Counter pins at all-ones rather than wrapping.
      if (w_toggle && !w_cnt_sat)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o           = r_o;
  assign o_valid     = r_vld;
  assign sel_q       = r_sel_q;
  assign sel_changes = r_cnt;

`ifdef MUX2T1_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_par <= 1'b0;
    else if (in_valid)
      r_par <= ^w_sel_data;
  end

  assign o_par = r_par;
`endif

endmodule

// File: tb/tb_mux2t1_sync.sv
// Scoreboard bench for mux2t1_sync (WIDTH=4, CNT_W=2 so counter saturation is reachable).
module tb_mux2t1_sync;

  localparam int W  = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic [W-1:0]  o;
    logic          vld;
    logic          sq;
    logic [CW-1:0] cnt;
    logic          par;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  o;
  logic          o_valid;
  logic          sel_q;
  logic [CW-1:0] sel_changes;
`ifdef MUX2T1_PARITY_EN
  logic          o_par;
`endif

  mux2t1_sync #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .a(a), .b(b), .in_valid(in_valid),
    .o(o), .o_valid(o_valid), .sel_q(sel_q), .sel_changes(sel_changes)
`ifdef MUX2T1_PARITY_EN
    , .o_par(o_par)
`endif
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  // reference model state
  logic [W-1:0]  m_o   = '0;
  logic          m_vld = 1'b0;
  logic          m_sq  = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_par = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic s, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic v);
    exp_t e;
    logic [W-1:0] pick;
    @(negedge clk);
    rst_n = rst; sel = s; a = av; b = bv; in_valid = v;
    pick = s ? bv : av;
    if (!rst) begin
      m_o = '0; m_vld = 1'b0; m_sq = 1'b0; m_cnt = '0; m_par = 1'b0;
    end else begin
      if (v && (s != m_sq) && (m_cnt != 2'd3)) m_cnt = m_cnt + 2'd1;
      m_vld = v;
      if (v) begin
        m_o = pick; m_sq = s; m_par = ^pick;
      end
    end
    sb_q.push_back('{o: m_o, vld: m_vld, sq: m_sq, cnt: m_cnt, par: m_par});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("o",       32'(o),           32'(e.o));
    chk("o_valid", 32'(o_valid),     32'(e.vld));
    chk("sel_q",   32'(sel_q),       32'(e.sq));
    chk("cnt",     32'(sel_changes), 32'(e.cnt));
`ifdef MUX2T1_PARITY_EN
    chk("o_par",   32'(o_par),       32'(e.par));
`endif
  endtask

  initial begin
    // reset with active-looking inputs
    drive(1'b0, 1'b1, 4'h1, 4'h1, 1'b1);
    drive(1'b0, 1'b1, 4'h1, 4'h1, 1'b1);
    chk("rst_o_lit",   32'(o), 32'd0);
    chk("rst_cnt_lit", 32'(sel_changes), 32'd0);

    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    chk("cap0_vld_lit", 32'(o_valid), 32'd1);
    drive(1'b1, 1'b0, 4'h1, 4'h0, 1'b1);
    chk("cap1_o_lit", 32'(o), 32'd1);
    drive(1'b1, 1'b1, 4'h0, 4'h1, 1'b1);
    chk("cap2_cnt_lit", 32'(sel_changes), 32'd1);

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    chk("hold_o_lit", 32'(o), 32'd1);

    // a == b: result independent of sel
    drive(1'b1, 1'b1, 4'hA, 4'hA, 1'b1);
    drive(1'b1, 1'b0, 4'hA, 4'hA, 1'b1);
    chk("aeqb_lit", 32'(o), 32'hA);

    // saturation: five toggling accepted cycles
    for (int i = 0; i < 5; i++) drive(1'b1, i[0], 4'h3, 4'hC, 1'b1);
    chk("sat_lit", 32'(sel_changes), 32'd3);
    drive(1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
    chk("midrst_cnt_lit", 32'(sel_changes), 32'd0);
    chk("midrst_o_lit",   32'(o), 32'd0);

    for (int i = 0; i < 60; i++)
      drive(($urandom_range(15) != 0), 1'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(3) != 0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
